key_event_sequencer: RTL and testbench
======================================

Name: key_event_sequencer

Overview:
- Avalon-MM master that owns and sequences the 4-bit key PIO slave (data / irq_mask / edge_capture registers at word addresses 0/2/3).
- Programs the interrupt mask, waits for the PIO irq, reads and clears edge_capture, then queues one event per captured key into a small FIFO.
- Hardware consumers (game/FSM logic) take key presses from this FIFO without Nios II involvement.
- Sits beside the key PIO in the system; the PIO's slave port is driven only by this block.

Parameters:
- NUM_KEYS, 4, number of key bits handled (1-32).
- KEY_MASK, 4'hF, value written to irq_mask at enable; bits above NUM_KEYS are ignored.
- FIFO_DEPTH, 8, event FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  level; 1 = sequencer active.
- m_address  out  2  PIO word address.
- m_chipselect  out  1  PIO chipselect.
- m_write_n  out  1  active-low write strobe.
- m_writedata  out  32  PIO write data.
- m_readdata  in  32  PIO registered read data.
- pio_irq  in  1  PIO irq output.
- evt_valid  out  1  FIFO not empty.
- evt_ready  in  1  consumer accepts the head entry.
- evt_key  out  clog2(NUM_KEYS), minimum 1  key index of the head entry.
- evt_overflow  out  1  sticky flag: an event was dropped.
- ovf_clear  in  1  clears evt_overflow.
- busy  out  1  FSM not in IDLE or WAIT_IRQ.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. All outputs are 0 except m_write_n = 1. FSM goes to IDLE, FIFO empties, captured-bit register clears.
- Bus rules:
  - Every access is one cycle with chipselect = 1; there is no waitrequest.
  - Reads: m_write_n = 1. m_readdata is valid in the cycle after the read cycle.
  - Outside accesses: m_chipselect = 0, m_write_n = 1, m_address = 0, m_writedata = 0.
- FSM:
  - IDLE: if enable, go to INIT (IDLE → INIT).
  - INIT: write address 2, data = KEY_MASK & ((1<<NUM_KEYS)-1). Next: WAIT_IRQ.
  - WAIT_IRQ: if !enable, go to DISARM. Else if pio_irq, go to RD.
  - RD: read address 3. Next: LATCH.
  - LATCH: cap ← m_readdata[NUM_KEYS-1:0] & mask. If cap == 0, go to WAIT_IRQ (spurious). Otherwise go to CLR.
  - CLR: write address 3, data = cap (write-1-to-clear; clears only the bits captured). Next: DISPATCH.
  - DISPATCH: one cycle per set bit of cap, lowest index first. Push the index, then clear that bit of cap. When cap == 0, go to WAIT_IRQ, or to DISARM if !enable.
  - DISARM: write address 2, data 0. Next: IDLE.
- Edges that arrive between RD and CLR remain set in the PIO. irq stays high, so they are serviced in the next RD; no edge is lost.
- enable is sampled only in IDLE, WAIT_IRQ and at the exit of DISPATCH; an in-flight sequence always completes.
- FIFO:
  - Pop when evt_valid && evt_ready. evt_key always shows the head entry (first-word fall-through).
  - Push while full and no pop in the same cycle: entry dropped, evt_overflow set, dispatch continues.
  - Push and pop together while full: both succeed.
  - Pointers use wrap-around with an extra bit to tell full from empty.
- evt_overflow: set dominates ovf_clear in the same cycle.
- Latency from pio_irq high in WAIT_IRQ to the first evt_valid: 4 cycles (RD, LATCH, CLR, DISPATCH push). evt_valid rises the cycle after the push.

Decomposition:
- Package key_seq_pkg:
  - State enum (IDLE, INIT, WAIT_IRQ, RD, LATCH, CLR, DISPATCH, DISARM).
  - Address constants ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3.
- Sub-module key_event_fifo: parameterised FWFT sync FIFO (push, data, full, pop, valid, head).
- Top level holds the FSM, the cap register and the overflow flag.

Test Plan:
- Bring-up: reset, then enable = 1 → one write {addr 2, data 0xF} in cycle 2. FSM reaches WAIT_IRQ; busy = 0.
- Single press: PIO model edge_capture = 0x4, irq = 1 → read addr 3, write {addr 3, data 0x4}, one event evt_key = 2. evt_valid asserts 4 cycles after irq (plus 1).
- Multi press: edge_capture = 0xB → clear data 0xB; events 0, 1, 3 in order; PIO edge_capture returns to 0.
- Overflow: FIFO_DEPTH = 2, evt_ready = 0, edge_capture = 0x7 → two events queued, evt_overflow = 1. After ovf_clear, evt_overflow = 0; draining yields keys 0 then 1.
- Spurious read: irq high with edge_capture reading 0 → no CLR write, no event, returns to WAIT_IRQ.
- Disable mid-DISPATCH with 0x3 captured → both events pushed, then write {addr 2, data 0}, then IDLE. Asserting reset_n = 0 mid-CLR instead → outputs return to reset values immediately.

Source files
------------

// File: rtl/key_event_sequencer_pkg.sv
// Shared types and constants for the key event sequencer: FSM state encoding,
// key PIO register map and lowest-set-bit helpers used while dispatching.
package key_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        WAIT_IRQ,
        RD,
        LATCH,
        CLR,
        DISPATCH,
        DISARM
    } state_e;

    // Key PIO word addresses
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    // Isolates the lowest set bit of v (zero when v is zero)
    function automatic logic [31:0] lowest_onehot(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

    // Binary index of a one-hot vector (zero when no bit is set)
    function automatic logic [4:0] onehot_index(input logic [31:0] oh);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = idx | 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_event_sequencer_if.sv
// Avalon-MM link between the sequencer (master) and the key PIO (slave),
// including the PIO interrupt line that travels back with the read data.
interface key_event_sequencer_if;

    logic [1:0]  m_address;
    logic        m_chipselect;
    logic        m_write_n;
    logic [31:0] m_writedata;
    logic [31:0] m_readdata;
    logic        pio_irq;

    modport master (
        output m_address,
        output m_chipselect,
        output m_write_n,
        output m_writedata,
        input  m_readdata,
        input  pio_irq
    );

    modport slave (
        input  m_address,
        input  m_chipselect,
        input  m_write_n,
        input  m_writedata,
        output m_readdata,
        output pio_irq
    );

endinterface

// File: rtl/key_event_sequencer_fifo.sv
// First-word fall-through synchronous FIFO for key events. Pointers carry one
// extra wrap bit so full and empty are distinguishable. A push that finds the
// FIFO full is dropped unless a pop frees the slot in the same cycle.
module key_event_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic             drop_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             empty;
    logic             do_pop;
    logic             accept;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty;
    assign accept  = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && !accept;
    assign valid_o = !empty;
    // Head reads as zero while empty so the output is defined out of reset
    assign head_o  = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    // Advance read/write pointers on accepted pushes and pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, whatever the statement order.
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Store accepted entries
    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/key_event_sequencer.sv
// Avalon-MM master that owns the 4-register key PIO: arms its interrupt mask,
// services each irq by reading and clearing edge_capture, and turns every
// captured key into one event in a FWFT FIFO for hardware consumers.
module key_event_sequencer
    import key_seq_pkg::*;
#(
    parameter int          NUM_KEYS   = 4,
    parameter logic [31:0] KEY_MASK   = 32'hF,
    parameter int          FIFO_DEPTH = 8,
    localparam int         KEY_W      = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    key_event_sequencer_if.master bus,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [KEY_W-1:0]      evt_key,
    output logic                  evt_overflow,
    input  logic                  ovf_clear,
    output logic                  busy
);

    // Mask bits above NUM_KEYS are dropped by the slice
    localparam logic [NUM_KEYS-1:0] IRQ_MASK = KEY_MASK[NUM_KEYS-1:0];

    state_e              state_q;
    state_e              state_d;
    logic [NUM_KEYS-1:0] cap_q;
    logic [NUM_KEYS-1:0] cap_d;
    logic                ovf_q;
    logic                ovf_d;

    logic [NUM_KEYS-1:0] latch_val;
    logic [31:0]         low_oh;
    logic [4:0]          low_idx;

    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_drop;

    // Edge bits read back from the PIO, restricted to the keys we armed
    assign latch_val = bus.m_readdata[NUM_KEYS-1:0] & IRQ_MASK;
    assign low_oh    = lowest_onehot(32'(cap_q));
    assign low_idx   = onehot_index(low_oh);

    // Read-data bits above NUM_KEYS and the high helper bits are don't-care
    logic unused_bits;
    assign unused_bits = ^{bus.m_readdata, low_oh, low_idx};

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable only matters in IDLE, WAIT_IRQ and DISPATCH exit
    always_comb begin
        // NOTE: every variable gets a default first so no path through the block infers a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (enable) state_d = INIT;
            INIT:     state_d = WAIT_IRQ;
            WAIT_IRQ: begin
                if (!enable) begin
                    state_d = DISARM;
                end else if (bus.pio_irq) begin
                    state_d = RD;
                end
            end
            RD:       state_d = LATCH;
            LATCH:    state_d = (latch_val == '0) ? WAIT_IRQ : CLR;
            CLR:      state_d = DISPATCH;
            DISPATCH: begin
                if (cap_d == '0) begin
                    state_d = enable ? WAIT_IRQ : DISARM;
                end
            end
            DISARM:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Captured-key register: loaded in LATCH, one bit retired per DISPATCH cycle
    always_comb begin
        cap_d = cap_q;
        if (state_q == LATCH) begin
            cap_d = latch_val;
        end else if (state_q == DISPATCH) begin
            cap_d = cap_q & ~low_oh[NUM_KEYS-1:0];
        end
    end

    // Hold the captured-key set across CLR and DISPATCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_q <= '0;
        end else begin
            cap_q <= cap_d;
        end
    end

    // Bus strobes and FIFO push decoded from the current state
    always_comb begin
        bus.m_chipselect = 1'b0;
        bus.m_write_n    = 1'b1;
        bus.m_address    = ADDR_DATA;
        bus.m_writedata  = '0;
        push             = 1'b0;
        unique case (state_q)
            INIT: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = ADDR_MASK;
                bus.m_writedata  = 32'(IRQ_MASK);
            end
            RD: begin
                bus.m_chipselect = 1'b1;
                bus.m_address    = ADDR_EDGE;
            end
            CLR: begin
                // Write-1-to-clear only the bits we captured; later edges stay pending
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = ADDR_EDGE;
                bus.m_writedata  = 32'(cap_q);
            end
            DISPATCH: begin
                push = 1'b1;
            end
            DISARM: begin
                bus.m_chipselect = 1'b1;
                bus.m_write_n    = 1'b0;
                bus.m_address    = ADDR_MASK;
            end
            default: begin
            end
        endcase
    end

    assign busy = !(state_q inside {IDLE, WAIT_IRQ});
    assign pop  = evt_valid && evt_ready;

    key_event_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_n),
        .push_i  (push),
        .data_i  (low_idx[KEY_W-1:0]),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .valid_o (evt_valid),
        .head_o  (evt_key),
        .drop_o  (fifo_drop)
    );

    // Sticky overflow: a drop in the same cycle wins over ovf_clear
    always_comb begin
        ovf_d = ovf_q;
        if (fifo_drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clear) begin
            ovf_d = 1'b0;
        end
    end

    // Overflow flag register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign evt_overflow = ovf_q;

    // fifo_full is implied by fifo_drop; kept visible for debug probes
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_key_event_sequencer.sv
// Self-checking bench for key_event_sequencer with a behavioural key PIO
// (irq_mask, edge_capture with write-1-to-clear, registered read data).
module tb_key_event_sequencer;
    import key_seq_pkg::*;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       enable    = 1'b0;
    logic       evt_ready = 1'b0;
    logic       ovf_clear = 1'b0;
    logic       evt_valid;
    logic       evt_overflow;
    logic       busy;
    logic [1:0] evt_key;

    key_event_sequencer_if bus ();

    key_event_sequencer #(
        .NUM_KEYS   (4),
        .KEY_MASK   (32'hF),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .bus          (bus),
        .evt_valid    (evt_valid),
        .evt_ready    (evt_ready),
        .evt_key      (evt_key),
        .evt_overflow (evt_overflow),
        .ovf_clear    (ovf_clear),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // ---------------- key PIO model ----------------
    logic [3:0]  edge_q    = '0;
    logic [3:0]  mask_q    = '0;
    logic [31:0] rdata_q   = '0;
    logic [3:0]  press     = '0;
    logic        force_irq = 1'b0;
    logic [3:0]  clr_bits;

    always @(posedge clk) begin
        clr_bits = '0;
        if (bus.m_chipselect && bus.m_write_n) begin
            case (bus.m_address)
                2'd2:    rdata_q <= {28'd0, mask_q};
                2'd3:    rdata_q <= {28'd0, edge_q};
                default: rdata_q <= '0;
            endcase
        end
        if (bus.m_chipselect && !bus.m_write_n) begin
            if (bus.m_address == 2'd2) mask_q <= bus.m_writedata[3:0];
            if (bus.m_address == 2'd3) clr_bits = bus.m_writedata[3:0];
        end
        edge_q <= (edge_q & ~clr_bits) | press;
    end

    assign bus.m_readdata = rdata_q;
    assign bus.pio_irq    = (|(edge_q & mask_q)) | force_irq;

    // ---------------- bus / event logs ----------------
    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } acc_t;

    acc_t       bus_log [$];
    logic [1:0] evt_log [$];

    always @(negedge clk) begin
        if (bus.m_chipselect)
            bus_log.push_back('{wr: !bus.m_write_n, addr: bus.m_address, data: bus.m_writedata});
        if (evt_valid && evt_ready)
            evt_log.push_back(evt_key);
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] edges;   // 0 = spurious irq with nothing captured
        int         n_evt;
        logic [1:0] keys [4];
    } vec_t;

    function automatic vec_t mk(input logic [3:0] e, input int n,
                                input logic [1:0] k0, input logic [1:0] k1,
                                input logic [1:0] k2, input logic [1:0] k3);
        vec_t v;
        v.edges = e;
        v.n_evt = n;
        v.keys[0] = k0;
        v.keys[1] = k1;
        v.keys[2] = k2;
        v.keys[3] = k3;
        return v;
    endfunction

    task automatic wait_clr_write(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.m_chipselect && !bus.m_write_n && bus.m_address == 2'd3) found = 1'b1;
        end
        check(name, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [7];
        int   lat;
        logic seen;

        vecs[0] = mk(4'h4, 1, 2'd2, 2'd0, 2'd0, 2'd0);
        vecs[1] = mk(4'hB, 3, 2'd0, 2'd1, 2'd3, 2'd0);
        vecs[2] = mk(4'h1, 1, 2'd0, 2'd0, 2'd0, 2'd0);
        vecs[3] = mk(4'h8, 1, 2'd3, 2'd0, 2'd0, 2'd0);
        vecs[4] = mk(4'hF, 4, 2'd0, 2'd1, 2'd2, 2'd3);
        vecs[5] = mk(4'h6, 2, 2'd1, 2'd2, 2'd0, 2'd0);
        vecs[6] = mk(4'h0, 0, 2'd0, 2'd0, 2'd0, 2'd0);

        // ---- reset values ----
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cs",      32'(bus.m_chipselect), 32'd0);
        check("rst_write_n", 32'(bus.m_write_n),    32'd1);
        check("rst_addr",    32'(bus.m_address),    32'd0);
        check("rst_wdata",   bus.m_writedata,       32'd0);
        check("rst_valid",   32'(evt_valid),        32'd0);
        check("rst_key",     32'(evt_key),          32'd0);
        check("rst_ovf",     32'(evt_overflow),     32'd0);
        check("rst_busy",    32'(busy),             32'd0);

        // ---- bring-up: mask write in the cycle after enable ----
        reset_n = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("init_cs",      32'(bus.m_chipselect), 32'd1);
        check("init_write_n", 32'(bus.m_write_n),    32'd0);
        check("init_addr",    32'(bus.m_address),    32'd2);
        check("init_wdata",   bus.m_writedata,       32'hF);
        check("init_busy",    32'(busy),             32'd1);
        @(negedge clk);
        check("wait_busy",    32'(busy),             32'd0);
        check("wait_cs",      32'(bus.m_chipselect), 32'd0);
        check("pio_mask",     32'(mask_q),           32'hF);

        // ---- irq-to-evt_valid latency ----
        evt_ready = 1'b1;
        bus_log.delete();
        evt_log.delete();
        press = 4'h4;
        @(negedge clk);
        press = '0;
        check("lat_irq", 32'(bus.pio_irq), 32'd1);
        lat = 0;
        while (!evt_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        repeat (5) @(negedge clk);
        check("lat_key", 32'(evt_log.size() > 0 ? evt_log[0] : 2'd0), 32'd2);

        // ---- table: single/multi press and spurious irq ----
        for (int i = 0; i < 7; i++) begin
            bus_log.delete();
            evt_log.delete();
            @(negedge clk);
            if (vecs[i].edges == 4'h0) force_irq = 1'b1;
            else                       press = vecs[i].edges;
            @(negedge clk);
            force_irq = 1'b0;
            press     = '0;
            repeat (15) @(negedge clk);
            check($sformatf("v%0d_nbus", i), 32'(bus_log.size()),
                  (vecs[i].edges == 4'h0) ? 32'd1 : 32'd2);
            if (bus_log.size() > 0)
                check($sformatf("v%0d_rd", i), {29'd0, bus_log[0].wr, bus_log[0].addr}, 32'd3);
            if (bus_log.size() > 1) begin
                check($sformatf("v%0d_clr_addr", i), {29'd0, bus_log[1].wr, bus_log[1].addr}, 32'd7);
                check($sformatf("v%0d_clr_data", i), bus_log[1].data, {28'd0, vecs[i].edges});
            end
            check($sformatf("v%0d_nevt", i), 32'(evt_log.size()), 32'(vecs[i].n_evt));
            for (int j = 0; j < vecs[i].n_evt && j < evt_log.size(); j++)
                check($sformatf("v%0d_key%0d", i, j), 32'(evt_log[j]), 32'(vecs[i].keys[j]));
            check($sformatf("v%0d_edge", i), 32'(edge_q), 32'd0);
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // ---- overflow with FIFO_DEPTH = 2 ----
        evt_ready = 1'b0;
        bus_log.delete();
        @(negedge clk);
        press = 4'h7;
        @(negedge clk);
        press = '0;
        repeat (15) @(negedge clk);
        check("ovf_set",   32'(evt_overflow), 32'd1);
        check("ovf_valid", 32'(evt_valid),    32'd1);
        check("ovf_head",  32'(evt_key),      32'd0);
        check("ovf_clr_data", bus_log.size() > 1 ? bus_log[1].data : 32'hDEAD, 32'h7);
        check("ovf_edge",  32'(edge_q),       32'd0);
        ovf_clear = 1'b1;
        @(negedge clk);
        ovf_clear = 1'b0;
        check("ovf_cleared", 32'(evt_overflow), 32'd0);

        // drop while ovf_clear held: the set must win for one cycle
        ovf_clear = 1'b1;
        press = 4'h1;
        @(negedge clk);
        press = '0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (evt_overflow) seen = 1'b1;
        end
        check("ovf_set_dominates", 32'(seen), 32'd1);
        ovf_clear = 1'b0;
        check("ovf_after_hold", 32'(evt_overflow), 32'd0);

        // drain: keys 0 then 1
        check("drain0_valid", 32'(evt_valid), 32'd1);
        check("drain0_key",   32'(evt_key),   32'd0);
        evt_ready = 1'b1;
        @(negedge clk);
        check("drain1_valid", 32'(evt_valid), 32'd1);
        check("drain1_key",   32'(evt_key),   32'd1);
        @(negedge clk);
        check("drain_empty",  32'(evt_valid), 32'd0);

        // ---- disable while a sequence is in flight ----
        bus_log.delete();
        evt_log.delete();
        press = 4'h3;
        @(negedge clk);
        press = '0;
        wait_clr_write("dis_found_clr");
        enable = 1'b0;
        repeat (10) @(negedge clk);
        check("dis_nbus", 32'(bus_log.size()), 32'd3);
        if (bus_log.size() > 2) begin
            check("dis_disarm_addr", {29'd0, bus_log[2].wr, bus_log[2].addr}, 32'd6);
            check("dis_disarm_data", bus_log[2].data, 32'd0);
        end
        check("dis_nevt", 32'(evt_log.size()), 32'd2);
        if (evt_log.size() > 1) begin
            check("dis_key0", 32'(evt_log[0]), 32'd0);
            check("dis_key1", 32'(evt_log[1]), 32'd1);
        end
        check("dis_mask", 32'(mask_q), 32'd0);
        check("dis_busy", 32'(busy),   32'd0);

        // ---- reset asserted during CLR ----
        enable = 1'b1;
        repeat (4) @(negedge clk);
        evt_log.delete();
        press = 4'h2;
        @(negedge clk);
        press = '0;
        wait_clr_write("rstclr_found_clr");
        reset_n = 1'b0;
        #1;
        check("rstclr_cs",      32'(bus.m_chipselect), 32'd0);
        check("rstclr_write_n", 32'(bus.m_write_n),    32'd1);
        check("rstclr_addr",    32'(bus.m_address),    32'd0);
        check("rstclr_wdata",   bus.m_writedata,       32'd0);
        check("rstclr_busy",    32'(busy),             32'd0);
        check("rstclr_valid",   32'(evt_valid),        32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        check("rstclr_edge_kept", 32'(edge_q), 32'h2);
        repeat (20) @(negedge clk);
        check("rstclr_nevt", 32'(evt_log.size()), 32'd1);
        check("rstclr_key",  32'(evt_log.size() > 0 ? evt_log[0] : 2'd0), 32'd1);
        check("rstclr_edge", 32'(edge_q), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
